// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified byte-memory port arbiter.
//   state_t        : sequencer states
//   own_t          : which requester owns the current transaction
//   BYTES_PER_WORD : bytes serialised per 32-bit access
//   ADDR_W_DEF     : default byte-address width of the memory array
package mem_arb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;
  localparam int ADDR_W_DEF     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP,
    ST_HALTED
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } own_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant between fetch and data requesters.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req_if       : fetch side requesting
//   i_req_dm       : data side requesting
//   i_upd          : commit i_upd_own as the most recent grant
//   i_upd_own      : owner of the transaction being completed
//   o_grant        : combinational winner for the current cycle
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_if,
  input  logic i_req_dm,
  input  logic i_upd,
  input  own_t i_upd_own,
  output own_t o_grant
);

  own_t r_last;

  // Last grant resets to fetch so that data wins the first tie.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last <= OWN_IF;
    end else if (i_upd) begin
      r_last <= i_upd_own;
    end
  end

  always_comb begin
    o_grant = OWN_IF;
    if (i_req_dm && (!i_req_if || (r_last == OWN_IF))) begin
      o_grant = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide unified memory between instruction fetch and the
// load/store unit. Each 32-bit access is serialised into four big-endian
// byte accesses; a halt path drains the in-flight access then freezes the
// memory port.
// Ports:
//   mem_Clk, mem_Rst_n          : clock, synchronous active-low reset
//   if_req/if_addr              : fetch request (level) and byte address
//   if_rdata/if_ack             : fetched word and one-cycle completion pulse
//   dm_read/dm_write/dm_addr    : load/store request (level) and byte address
//   dm_wdata                    : store data
//   dm_rdata/dm_ack/dm_err      : load data, completion pulse, read+write error
//   halt_req/halted             : drain-and-freeze request and status
//   mem_a/mem_we/mem_wd/mem_rd  : byte memory port (mem_rd one cycle latent)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              mem_Clk,
  input  logic              mem_Rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              dm_err,
  input  logic              halt_req,
  output logic              halted,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [7:0]        mem_wd,
  input  logic [7:0]        mem_rd
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic                w_start;
  logic [ADDR_W-1:0]   r_base;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_rdata;
  own_t                r_own;
  logic                r_err;
  logic                r_halt_pend;
  logic [WORD_W-1:0]   r_if_rdata;
  logic [WORD_W-1:0]   r_dm_rdata;
  logic [WORD_W-1:0]   w_rd_word;
  logic                w_dm_req;
  own_t                w_grant;
  logic                w_rd_last;
  logic                w_wr_last;
  logic                w_unused;

  localparam logic [2:0] RD_LAST = 3'(BYTES_PER_WORD);
  localparam logic [2:0] WR_LAST = 3'(BYTES_PER_WORD - 1);

  // Byte 0 of a word is its most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign w_unused  = &{1'b0, if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};
  assign w_dm_req  = dm_read | dm_write;
  assign w_rd_last = (r_state == ST_RD) && (r_cnt == RD_LAST);
  assign w_wr_last = (r_state == ST_WR) && (r_cnt == WR_LAST);
  // The final read byte arrives in the last RD cycle; merge it on the way out.
  assign w_rd_word = {r_rdata[31:8], mem_rd};

  mem_arb_rr2 u_rr (
    .i_clk     (mem_Clk),
    .i_rst_n   (mem_Rst_n),
    .i_req_if  (if_req),
    .i_req_dm  (w_dm_req),
    .i_upd     (r_state == ST_RESP),
    .i_upd_own (r_own),
    .o_grant   (w_grant)
  );

  always_ff @(posedge mem_Clk) begin
    if (!mem_Rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_halt_pend <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      // A halt seen mid-transaction is remembered until the next IDLE.
      r_halt_pend <= r_halt_pend | halt_req;
      if (w_rd_last) begin
        if (r_own == OWN_IF) r_if_rdata <= w_rd_word;
        else                 r_dm_rdata <= w_rd_word;
      end else if (w_wr_last) begin
        if (r_own == OWN_IF) r_if_rdata <= r_rdata;
        else                 r_dm_rdata <= r_rdata;
      end
    end
  end

  // Transaction context and read assembly carry no reset: they are only
  // observed after a grant has loaded them.
  always_ff @(posedge mem_Clk) begin
    if (w_start) begin
      r_base  <= (w_grant == OWN_IF) ? if_addr[ADDR_W-1:0] : dm_addr[ADDR_W-1:0];
      r_wdata <= dm_wdata;
      r_own   <= w_grant;
      r_err   <= (w_grant == OWN_DM) && dm_read && dm_write;
    end
    if (r_state == ST_RD) begin
      case (r_cnt)
        3'd1:    r_rdata[31:24] <= mem_rd;
        3'd2:    r_rdata[23:16] <= mem_rd;
        3'd3:    r_rdata[15:8]  <= mem_rd;
        3'd4:    r_rdata[7:0]   <= mem_rd;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    mem_a       = '0;
    mem_we      = 1'b0;
    mem_wd      = 8'd0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (halt_req || r_halt_pend) begin
          w_state_nxt = ST_HALTED;
        end else if (if_req || w_dm_req) begin
          w_start     = 1'b1;
          // Read+write together executes as a store.
          w_state_nxt = ((w_grant == OWN_DM) && dm_write) ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (r_cnt < RD_LAST) mem_a = r_base + ADDR_W'(r_cnt);
        if (w_rd_last) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_WR: begin
        // Gated by reset so a reset cycle never commits a further byte.
        mem_we = mem_Rst_n;
        mem_a  = r_base + ADDR_W'(r_cnt);
        mem_wd = word_byte(r_wdata, r_cnt[1:0]);
        if (w_wr_last) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign if_ack   = (r_state == ST_RESP) && (r_own == OWN_IF);
  assign dm_ack   = (r_state == ST_RESP) && (r_own == OWN_DM);
  assign dm_err   = dm_ack && r_err;
  assign halted   = (r_state == ST_HALTED);
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_read, dm_write, halt_req;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_ack, dm_ack, dm_err, halted;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [7:0]  mem_wd, mem_rd;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         do_copy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16)) dut (
    .mem_Clk  (clk),
    .mem_Rst_n(rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .dm_read  (dm_read),
    .dm_write (dm_write),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .dm_err   (dm_err),
    .halt_req (halt_req),
    .halted   (halted),
    .mem_a    (mem_a),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  // Byte memory with registered read; preloaded from the reference image.
  always @(posedge clk) begin
    if (do_copy) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_a] <= mem_wd;
    end
    mem_rd <= mem[mem_a];
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a word is four consecutive bytes, MSB first, wrapping at 64K.
  function automatic logic [31:0] ref_load(input logic [31:0] a);
    logic [15:0] b;
    b = a[15:0];
    return {ref_mem[b], ref_mem[b + 16'd1], ref_mem[b + 16'd2], ref_mem[b + 16'd3]};
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d);
    logic [15:0] b;
    b = a[15:0];
    ref_mem[b]         = d[31:24];
    ref_mem[b + 16'd1] = d[23:16];
    ref_mem[b + 16'd2] = d[15:8];
    ref_mem[b + 16'd3] = d[7:0];
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_read = 0; dm_write = 0; halt_req = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    check("rst_ctl", {if_ack, dm_ack, dm_err, halted, mem_we, mem_a, mem_wd}, 64'd0);
    rst_n = 1;
  endtask

  // op: 0 fetch, 1 load, 2 store, 3 load+store
  task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input int exp_lat, input bit exp_err,
                         input string nm);
    int k, we_cnt;
    bit got, wrong, err;
    logic [31:0] rd;
    @(negedge clk);
    if (op == 0) begin
      if_req = 1; if_addr = addr;
    end else begin
      dm_addr = addr; dm_wdata = wdata;
      dm_read = (op == 1) || (op == 3);
      dm_write = (op >= 2);
    end
    k = 0; we_cnt = 0; got = 0; wrong = 0; err = 0; rd = '0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_we) we_cnt++;
      if ((op == 0) ? dm_ack : if_ack) wrong = 1;
      if ((op == 0) ? if_ack : dm_ack) begin
        got = 1;
        rd = (op == 0) ? if_rdata : dm_rdata;
        err = dm_err;
      end
    end
    idle_inputs();
    check({nm, "_lat"}, got ? k : -1, exp_lat);
    check({nm, "_err"}, err, exp_err);
    check({nm, "_we"}, we_cnt, (op >= 2) ? 4 : 0);
    check({nm, "_side"}, wrong, 0);
    if (op < 2) check({nm, "_rdata"}, rd, exp_rd);
    if (op >= 2) ref_store(addr, wdata);
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ak[8];
    int aw[8];
    logic [31:0] ad[8];
    int n, diffs, acks, wes;
    logic [31:0] a, d;
    int op;

    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[16'h0100] = 8'h12; ref_mem[16'h0101] = 8'h34;
    ref_mem[16'h0102] = 8'h56; ref_mem[16'h0103] = 8'h78;
    ref_mem[16'h0002] = 8'h5A;
    ref_mem[16'h0304] = 8'h99;
    do_copy = 1;
    repeat (2) @(posedge clk);
    do_copy = 0;

    do_reset();

    // Directed vectors: {op, addr, wdata, expected rdata, latency, err}
    vecs[0] = '{0, 32'h0000_0100, 32'h0,          32'h1234_5678, 6, 0};
    vecs[1] = '{2, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0,          5, 0};
    vecs[2] = '{1, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF, 6, 0};
    vecs[3] = '{2, 32'h0000_FFFE, 32'hAABB_CCDD, 32'h0,          5, 0};
    vecs[4] = '{1, 32'h0000_FFFF, 32'h0,          32'hBBCC_DD5A, 6, 0};
    vecs[5] = '{3, 32'h0000_0300, 32'h0102_0304, 32'h0,          5, 1};
    vecs[6] = '{0, 32'h0000_0301, 32'h0,          32'h0203_0499, 6, 0};
    vecs[7] = '{0, 32'hABCD_FFFE, 32'h0,          32'hAABB_CCDD, 6, 0};
    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
              vecs[i].exp_lat, vecs[i].exp_err, $sformatf("vec%0d", i));
    check("bytes_200", {mem[16'h0200], mem[16'h0201], mem[16'h0202], mem[16'h0203]}, 32'hDEAD_BEEF);
    check("bytes_wrap", {mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]}, 32'hAABB_CCDD);

    // Randomised traffic against the byte-array model.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0, 1:    a = {$urandom_range(0, 65535), 16'(16'h0F00 + $urandom_range(0, 31))};
        2:       a = {16'h0, 16'(16'hFFFC + $urandom_range(0, 3))};
        default: a = $urandom;
      endcase
      d = $urandom;
      run_txn(op, a, d, (op < 2) ? ref_load(a) : 32'h0, (op < 2) ? 6 : 5, op == 3,
              $sformatf("rnd%0d", i));
    end
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", diffs, 0);

    // Contention from reset: grants alternate DM, IF, DM, IF.
    do_reset();
    @(negedge clk);
    if_req = 1; if_addr = 32'h100; dm_read = 1; dm_addr = 32'h200;
    n = 0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if ((if_ack || dm_ack) && n < 8) begin
        ak[n] = k; aw[n] = dm_ack ? 1 : 0; ad[n] = dm_ack ? dm_rdata : if_rdata;
        n++;
      end
    end
    idle_inputs();
    check("cont_n", n, 4);
    for (int j = 0; j < 4; j++) begin
      if (j < n) begin
        check($sformatf("cont%0d_cyc", j), ak[j], 6 + 7 * j);
        check($sformatf("cont%0d_who", j), aw[j], (j % 2 == 0) ? 1 : 0);
        check($sformatf("cont%0d_rdata", j), ad[j], (j % 2 == 0) ? ref_load(32'h200) : ref_load(32'h100));
      end
    end
    repeat (3) @(negedge clk);

    // Halt during a store: store completes, then the port freezes.
    @(negedge clk);
    dm_write = 1; dm_addr = 32'h400; dm_wdata = 32'h1122_3344;
    acks = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 2) halt_req = 1;
      if (dm_ack) begin
        check("halt_ack_cyc", k, 5);
        acks++;
        dm_write = 0;
      end
      if (k == 6) check("halt_not_yet", halted, 0);
      if (k == 7) check("halt_set", halted, 1);
    end
    check("halt_acks", acks, 1);
    ref_store(32'h400, 32'h1122_3344);
    check("halt_bytes", {mem[16'h0400], mem[16'h0401], mem[16'h0402], mem[16'h0403]}, 32'h1122_3344);
    if_req = 1; if_addr = 32'h100;
    acks = 0; wes = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_ack || dm_ack) acks++;
      if (mem_we || mem_a != 0) wes++;
    end
    check("halted_acks", acks, 0);
    check("halted_port", wes, 0);
    check("halted_hold", halted, 1);

    // Reset during WR cnt=2 abandons the store after two bytes.
    do_reset();
    @(negedge clk);
    dm_write = 1; dm_addr = 32'h500; dm_wdata = 32'hCAFE_F00D;
    acks = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (if_ack || dm_ack) acks++;
      if (k == 3) begin
        rst_n = 0;
        dm_write = 0;
      end
      if (k == 4) begin
        check("mid_rst_rdata", {if_rdata, dm_rdata}, 64'd0);
        check("mid_rst_ctl", {if_ack, dm_ack, dm_err, halted, mem_we, mem_a, mem_wd}, 64'd0);
      end
    end
    rst_n = 1;
    repeat (8) @(negedge clk) if (if_ack || dm_ack) acks++;
    check("mid_rst_acks", acks, 0);
    ref_mem[16'h0500] = 8'hCA;
    ref_mem[16'h0501] = 8'hFE;
    check("mid_rst_bytes", {mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]}, ref_load(32'h500));
    run_txn(1, 32'h500, 32'h0, ref_load(32'h500), 6, 0, "post_rst_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
